prog_rom_arbiter: RTL and testbench

Two-port arbiter that shares the single synchronous-read program ROM (10-bit address, 18-bit word, one-cycle read latency) between the CPU instruction-fetch path and the debug/readback port. It issues at most one ROM read per clock and routes each returned word to the requester that issued it. Fetch has priority, and a starvation guard guarantees debug progress. It sits between the PC/fetch logic, the debug port and the ROM instance.

---
 rtl/prog_rom_arbiter_if.sv | 34 +++
 rtl/prog_rom_arbiter.sv | 109 ++++++++++
 tb/tb_prog_rom_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_rom_arbiter_if.sv
// Bus bundle between the fetch/debug requesters, the ROM arbiter and the
// synchronous-read program ROM.
interface prog_rom_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
);
  // Fetch port
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_valid;
  logic [DATA_W-1:0] f_data;
  // Debug port
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_data;
  // ROM side
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  // Requesters plus the ROM model: drive requests and ROM data, observe the rest
  modport master (
    output f_req, f_addr, d_req, d_addr, rom_data,
    input  f_gnt, f_valid, f_data, d_gnt, d_valid, d_data, rom_addr
  );

  // Arbiter view
  modport slave (
    input  f_req, f_addr, d_req, d_addr, rom_data,
    output f_gnt, f_valid, f_data, d_gnt, d_valid, d_data, rom_addr
  );
endinterface

// File: rtl/prog_rom_arbiter.sv
// Shares one synchronous-read program ROM between instruction fetch and the
// debug/readback port. One read is issued per clock; fetch has priority, and
// a debug request that has lost MAX_WAIT cycles in a row takes the next slot.
// Each returned word is steered to the port whose grant issued it, using a
// one-bit-per-port tag that travels alongside the ROM's one-cycle latency.
module prog_rom_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 18,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  prog_rom_arbiter_if.slave  bus
);

  // wait_cnt is 4 bits wide, so the limit is carried at that width
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  // Tag bit positions: {fetch, debug}
  localparam int F_IDX = 1;
  localparam int D_IDX = 0;

  logic [3:0]        wait_cnt_reg;
  logic [3:0]        wait_cnt_next;
  logic [1:0]        tag_reg;
  logic [1:0]        tag_next;
  logic [ADDR_W-1:0] last_addr_reg;
  logic [ADDR_W-1:0] rom_addr_next;
  logic              f_gnt;
  logic              d_gnt;
  logic              starved;
  logic [DATA_W-1:0] port_data [2];

  // Grant decision: fetch wins unless debug has waited its full budget
  always_comb begin
    starved = (wait_cnt_reg == WAIT_LIMIT);
    d_gnt   = bus.d_req && (!bus.f_req || starved);
    f_gnt   = bus.f_req && !d_gnt;
  end

  // ROM address mux; when idle, keep presenting the last issued address so
  // the ROM output does not change under a held DATA value
  always_comb begin
    rom_addr_next = last_addr_reg;
    if (f_gnt) begin
      rom_addr_next = bus.f_addr;
    end else if (d_gnt) begin
      rom_addr_next = bus.d_addr;
    end
  end

  // Starvation counter: counts consecutive cycles a debug request is refused
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (d_gnt || !bus.d_req) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg < WAIT_LIMIT) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end
  end

  // Issue tag for the read that returns next cycle
  always_comb begin
    tag_next        = '0;
    tag_next[F_IDX] = f_gnt;
    tag_next[D_IDX] = d_gnt;
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg  <= '0;
      tag_reg       <= '0;
      last_addr_reg <= '0;
    end else begin
      wait_cnt_reg  <= wait_cnt_next;
      tag_reg       <= tag_next;
      last_addr_reg <= rom_addr_next;
    end
  end

  // Per-port return path: bypass ROM data while valid, otherwise hold the
  // last word captured for that port
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] data_reg;

      // Capture the returned word for this port on the edge after VALID
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (tag_reg[gi]) begin
          data_reg <= bus.rom_data;
        end
      end

      assign port_data[gi] = tag_reg[gi] ? bus.rom_data : data_reg;
    end
  endgenerate

  assign bus.f_gnt    = f_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.rom_addr = rom_addr_next;
  assign bus.f_valid  = tag_reg[F_IDX];
  assign bus.d_valid  = tag_reg[D_IDX];
  assign bus.f_data   = port_data[F_IDX];
  assign bus.d_data   = port_data[D_IDX];

endmodule

// File: tb/tb_prog_rom_arbiter.sv
// Self-checking bench for prog_rom_arbiter: directed scenarios followed by
// randomized request traffic, all checked against a transaction-level model.
module tb_prog_rom_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 18;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic rst_n;

  prog_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ROM contents and the ROM's registered read port
  logic [DATA_W-1:0] rom_mem [1 << ADDR_W];

  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: the read in flight, words last delivered per port,
  // the last address issued and how long debug has been refused
  int                m_pend_port;   // 0 none, 1 fetch, 2 debug
  logic [ADDR_W-1:0] m_pend_addr;
  logic [DATA_W-1:0] m_hold_f;
  logic [DATA_W-1:0] m_hold_d;
  logic [ADDR_W-1:0] m_last_addr;
  int                m_refused;
  logic              m_gnt_f;
  logic              m_gnt_d;
  logic              obs_d_gnt;
  int                f_valid_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend_port = 0;
    m_pend_addr = '0;
    m_hold_f    = '0;
    m_hold_d    = '0;
    m_last_addr = '0;
    m_refused   = 0;
    m_gnt_f     = 1'b0;
    m_gnt_d     = 1'b0;
  endtask

  // One clock cycle: drive requests after the edge, check before the next
  task automatic step(input logic fr, input logic [ADDR_W-1:0] fa,
                      input logic dr, input logic [ADDR_W-1:0] da);
    logic              eg_f, eg_d, ev_f, ev_d;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ef, ed;
    @(posedge clk);
    #1;
    bus.f_req  = fr;
    bus.f_addr = fa;
    bus.d_req  = dr;
    bus.d_addr = da;
    #3;
    eg_d = dr && (!fr || m_refused >= MAX_WAIT);
    eg_f = fr && !eg_d;
    ea   = eg_f ? fa : (eg_d ? da : m_last_addr);
    ev_f = (m_pend_port == 1);
    ev_d = (m_pend_port == 2);
    ef   = ev_f ? rom_mem[m_pend_addr] : m_hold_f;
    ed   = ev_d ? rom_mem[m_pend_addr] : m_hold_d;
    check("f_gnt",    bus.f_gnt,    eg_f);
    check("d_gnt",    bus.d_gnt,    eg_d);
    check("rom_addr", bus.rom_addr, ea);
    check("f_valid",  bus.f_valid,  ev_f);
    check("d_valid",  bus.d_valid,  ev_d);
    check("f_data",   bus.f_data,   ef);
    check("d_data",   bus.d_data,   ed);
    if (ev_f) $display("[TB] %0t F read addr=0x%03h data=0x%05h", $time, m_pend_addr, bus.f_data);
    if (ev_d) $display("[TB] %0t D read addr=0x%03h data=0x%05h", $time, m_pend_addr, bus.d_data);
    if (ev_f) f_valid_cnt++;
    obs_d_gnt   = bus.d_gnt;
    m_hold_f    = ef;
    m_hold_d    = ed;
    m_pend_port = eg_f ? 1 : (eg_d ? 2 : 0);
    m_pend_addr = ea;
    if (eg_f || eg_d) m_last_addr = ea;
    m_refused   = (eg_d || !dr) ? 0 : m_refused + 1;
    m_gnt_f     = eg_f;
    m_gnt_d     = eg_d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    logic              fp, dp;
    logic [ADDR_W-1:0] fa, da;
    int                first_idx, gcount;

    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
    rst_n      = 1'b0;
    bus.f_req  = 1'b0;
    bus.f_addr = '0;
    bus.d_req  = 1'b0;
    bus.d_addr = '0;
    model_reset();
    f_valid_cnt = 0;

    // Reset state
    #2;
    check("rst f_valid",  bus.f_valid,  1'b0);
    check("rst d_valid",  bus.d_valid,  1'b0);
    check("rst f_data",   bus.f_data,   '0);
    check("rst d_data",   bus.d_data,   '0);
    check("rst rom_addr", bus.rom_addr, '0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single fetch, first grant right out of reset
    step(1'b1, 10'h005, 1'b0, '0);
    idle(2);

    // Streaming fetch 0x000..0x00F, no bubbles
    f_valid_cnt = 0;
    for (int i = 0; i < 16; i++) step(1'b1, ADDR_W'(i), 1'b0, '0);
    idle(1);
    check("stream valids", f_valid_cnt, 16);

    // Priority: fetch wins with no debug history, debug goes next
    step(1'b1, 10'h010, 1'b1, 10'h020);
    step(1'b0, '0,      1'b1, 10'h020);
    idle(2);

    // Starvation against continuous fetch
    first_idx = -1;
    gcount    = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b1, ADDR_W'(k + 100), 1'b1, 10'h3FF);
      if (obs_d_gnt) begin
        gcount++;
        if (first_idx < 0) first_idx = k;
      end
    end
    step(1'b1, 10'h200, 1'b0, '0);
    idle(2);
    check("starve first gnt cycle", first_idx, 4);
    check("starve gnt count", gcount, 3);

    // Idle hold after a grant at 0x123
    step(1'b1, 10'h123, 1'b0, '0);
    idle(10);

    // Reset while a fetch is in flight
    step(1'b1, 10'h077, 1'b0, '0);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    #1;
    check("midrst f_valid",  bus.f_valid,  1'b0);
    check("midrst d_valid",  bus.d_valid,  1'b0);
    check("midrst f_data",   bus.f_data,   '0);
    check("midrst d_data",   bus.d_data,   '0);
    check("midrst rom_addr", bus.rom_addr, '0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(3);

    // Randomized traffic; requests hold their address until granted and
    // are occasionally withdrawn before a grant
    fp = 1'b0; dp = 1'b0; fa = '0; da = '0;
    for (int i = 0; i < 600; i++) begin
      if (!fp) begin
        fp = ($urandom_range(0, 3) != 0);
        fa = ADDR_W'($urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        fp = 1'b0;
      end
      if (!dp) begin
        dp = ($urandom_range(0, 1) != 0);
        da = ADDR_W'($urandom);
      end else if ($urandom_range(0, 11) == 0) begin
        dp = 1'b0;
      end
      step(fp, fa, dp, da);
      if (m_gnt_f) fp = 1'b0;
      if (m_gnt_d) dp = 1'b0;
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
